// File: rtl/tmr_voter_ch.sv
// tmr_voter_ch: triple-modular-redundancy command voter with fault tracking and output slewing
//   clk, rst (async, active-high)
//   state      1 = vote across copies, 0 = pass copy A through
//   in_valid   command copies valid this cycle; clr_fault clears fault history
//   cmd_a/b/c  CH channels of W bits from the three redundant modules
//   cmd_o      voted command moving toward the registered target; settled = cmd_o equals target
//   fault      {A,B,C} mismatch on last valid sample; failed {A,B,C} sticky; no_maj no usable majority
//   Macro DTMR_SLEW_EN: limit each channel's per-cycle change to STEP; otherwise cmd_o follows target one cycle later
module tmr_voter_ch #(
  parameter int W        = 4,
  parameter int CH       = 2,
  parameter int STEP     = 1,
  parameter int FAULT_TH = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            state,
  input  logic            in_valid,
  input  logic            clr_fault,
  input  logic [CH*W-1:0] cmd_a,
  input  logic [CH*W-1:0] cmd_b,
  input  logic [CH*W-1:0] cmd_c,
  output logic [CH*W-1:0] cmd_o,
  output logic            settled,
  output logic [2:0]      fault,
  output logic [2:0]      failed,
  output logic            no_maj
);
  localparam int N = CH * W;
  logic [N-1:0] tgt_q, tgt_d, cmd_q, cmd_d, maj, pa, pb;
  logic [2:0]   fault_q, fault_d, failed_q, failed_d;
  logic [3:0]   cnt_q [3];
  logic [3:0]   cnt_d [3];
  logic         no_maj_q, no_maj_d;
  assign maj = (cmd_a & cmd_b) | (cmd_a & cmd_c) | (cmd_b & cmd_c);
  // With exactly one copy failed, pa/pb are the two survivors.
  assign pa = failed_q[2] ? cmd_b : cmd_a;
  assign pb = failed_q[0] ? cmd_b : cmd_c;
  always_comb begin
    tgt_d    = tgt_q;
    fault_d  = fault_q;
    no_maj_d = no_maj_q;
    failed_d = failed_q;
    cnt_d    = cnt_q;
    if (in_valid && !state) begin
      tgt_d    = cmd_a;
      fault_d  = '0;
      no_maj_d = 1'b0;
    end else if (in_valid) begin
      fault_d  = '0;
      no_maj_d = 1'b1;
      if (failed_q == 3'b000) begin
        tgt_d    = maj;
        fault_d  = {cmd_a != maj, cmd_b != maj, cmd_c != maj};
        no_maj_d = 1'b0;
      end else if ($onehot(failed_q) && pa == pb) begin
        tgt_d    = pa;
        no_maj_d = 1'b0;
      end
      for (int x = 0; x < 3; x++) begin
        cnt_d[x]    = fault_d[x] ? (&cnt_q[x] ? cnt_q[x] : cnt_q[x] + 4'd1) : 4'd0;
        failed_d[x] = failed_q[x] | (cnt_d[x] >= 4'(FAULT_TH));
      end
    end
    if (clr_fault) begin
      cnt_d    = '{default: 4'd0};
      failed_d = '0;
      no_maj_d = 1'b0;
    end
  end
`ifdef DTMR_SLEW_EN
  localparam logic [W-1:0] STEP_W = W'(STEP);
  for (genvar k = 0; k < CH; k++) begin : g_ch
    logic [W-1:0] tgt_c, cur_c;
    assign tgt_c = tgt_q[k*W +: W];
    assign cur_c = cmd_q[k*W +: W];
    // Step toward the target, landing exactly on it when the gap is within STEP.
    assign cmd_d[k*W +: W] = tgt_c > cur_c ? (tgt_c - cur_c > STEP_W ? cur_c + STEP_W : tgt_c)
                                           : (cur_c - tgt_c > STEP_W ? cur_c - STEP_W : tgt_c);
  end
`else
  assign cmd_d = tgt_q;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgt_q    <= '0;
      cmd_q    <= '0;
      fault_q  <= '0;
      failed_q <= '0;
      cnt_q    <= '{default: 4'd0};
      no_maj_q <= 1'b0;
    end else begin
      tgt_q    <= tgt_d;
      cmd_q    <= cmd_d;
      fault_q  <= fault_d;
      failed_q <= failed_d;
      cnt_q    <= cnt_d;
      no_maj_q <= no_maj_d;
    end
  end
  assign cmd_o   = cmd_q;
  assign settled = cmd_q == tgt_q;
  assign fault   = fault_q;
  assign failed  = failed_q;
  assign no_maj  = no_maj_q;
endmodule

// File: tb/tb_tmr_voter_ch.sv
// tb_tmr_voter_ch: directed and randomized checks of tmr_voter_ch against a behavioural model
module tb_tmr_voter_ch;
  localparam int W = 4, CH = 2, STEP = 1, FAULT_TH = 3, N = W * CH;
  logic clk = 0, rst = 1, state = 0, in_valid = 0, clr_fault = 0;
  logic [N-1:0] cmd_a = '0, cmd_b = '0, cmd_c = '0, cmd_o;
  logic settled, no_maj;
  logic [2:0] fault, failed;
  int n_chk = 0, n_bad = 0;
  int m_tgt [CH], m_cmd [CH], m_cnt [3];
  bit m_fault [3], m_failed [3], m_nomaj;
  always #5 clk = ~clk;
  tmr_voter_ch #(.W(W), .CH(CH), .STEP(STEP), .FAULT_TH(FAULT_TH)) dut (
    .clk(clk), .rst(rst), .state(state), .in_valid(in_valid), .clr_fault(clr_fault),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_c(cmd_c), .cmd_o(cmd_o), .settled(settled),
    .fault(fault), .failed(failed), .no_maj(no_maj));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int chan(input logic [N-1:0] v, input int k);
    logic [N-1:0] s;
    s = v >> (k * W);
    return int'(s[W-1:0]);
  endfunction
  function automatic logic [N-1:0] pack(input int a [CH]);
    logic [N-1:0] r;
    r = '0;
    for (int k = 0; k < CH; k++) r = r | (N'(a[k] & ((1 << W) - 1)) << (k * W));
    return r;
  endfunction
  task automatic model_reset();
    for (int k = 0; k < CH; k++) begin m_tgt[k] = 0; m_cmd[k] = 0; end
    for (int x = 0; x < 3; x++) begin m_cnt[x] = 0; m_fault[x] = 0; m_failed[x] = 0; end
    m_nomaj = 0;
  endtask
  // Copy index 0=A, 1=B, 2=C.
  task automatic model_step();
    logic [N-1:0] cp [3];
    int healthy [$];
    int d, mv, ones;
    cp = '{cmd_a, cmd_b, cmd_c};
    for (int k = 0; k < CH; k++) begin
      d = m_tgt[k] - m_cmd[k];
`ifdef DTMR_SLEW_EN
      m_cmd[k] += d > 0 ? (d < STEP ? d : STEP) : -((-d) < STEP ? -d : STEP);
`else
      m_cmd[k] = m_tgt[k];
`endif
    end
    if (in_valid && !state) begin
      for (int k = 0; k < CH; k++) m_tgt[k] = chan(cmd_a, k);
      m_fault = '{0, 0, 0};
      m_nomaj = 0;
    end else if (in_valid) begin
      for (int x = 0; x < 3; x++) if (!m_failed[x]) healthy.push_back(x);
      m_fault = '{0, 0, 0};
      m_nomaj = 1;
      if (healthy.size() == 3) begin
        m_nomaj = 0;
        for (int k = 0; k < CH; k++) begin
          mv = 0;
          for (int i = 0; i < W; i++) begin
            ones = 0;
            for (int x = 0; x < 3; x++) ones += (chan(cp[x], k) >> i) & 1;
            if (ones >= 2) mv += 1 << i;
          end
          for (int x = 0; x < 3; x++) if (chan(cp[x], k) != mv) m_fault[x] = 1;
          m_tgt[k] = mv;
        end
      end else if (healthy.size() == 2 && cp[healthy[0]] == cp[healthy[1]]) begin
        m_nomaj = 0;
        for (int k = 0; k < CH; k++) m_tgt[k] = chan(cp[healthy[0]], k);
      end
      for (int x = 0; x < 3; x++) begin
        m_cnt[x] = m_fault[x] ? (m_cnt[x] < 15 ? m_cnt[x] + 1 : 15) : 0;
        if (m_cnt[x] >= FAULT_TH) m_failed[x] = 1;
      end
    end
    if (clr_fault) begin
      for (int x = 0; x < 3; x++) begin m_cnt[x] = 0; m_failed[x] = 0; end
      m_nomaj = 0;
    end
  endtask
  task automatic check_all();
    chk("cmd_o", 32'(cmd_o), 32'(pack(m_cmd)));
    chk("settled", 32'(settled), 32'(pack(m_cmd) == pack(m_tgt)));
    chk("fault", 32'(fault), 32'({m_fault[0], m_fault[1], m_fault[2]}));
    chk("failed", 32'(failed), 32'({m_failed[0], m_failed[1], m_failed[2]}));
    chk("no_maj", 32'(no_maj), 32'(m_nomaj));
  endtask
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask
  task automatic drv(input logic st, input logic v, input logic clr,
                     input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] c);
    state = st; in_valid = v; clr_fault = clr; cmd_a = a; cmd_b = b; cmd_c = c;
  endtask
  task automatic pulse_rst();
    rst = 1;
    #1;
    model_reset();
    check_all();
    chk("rst_cmd_o", 32'(cmd_o), 32'h0);
    chk("rst_settled", 32'(settled), 32'h1);
    #1;
    rst = 0;
  endtask
  initial begin
    logic [N-1:0] base, fb, fc;
    model_reset();
    #1;
    check_all();
    chk("reset_settled", 32'(settled), 32'h1);
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    // Unanimous copies, one valid pulse, then watch the ramp.
    drv(1, 1, 0, 8'h5A, 8'h5A, 8'h5A);
    step();
    chk("r26_fault", 32'(fault), 32'h0);
    in_valid = 0;
    repeat (10) step();
    chk("r26_cmd", 32'(cmd_o), 32'h5A);
    chk("r26_settled", 32'(settled), 32'h1);
    // Copy C disagrees repeatedly until it is marked failed.
    drv(1, 1, 0, 8'h33, 8'h33, 8'h37);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("r27_fault", 32'(fault), 32'h1);
    end
    chk("r27_failed", 32'(failed), 32'h1);
    in_valid = 0;
    repeat (12) step();
    chk("r27_cmd", 32'(cmd_o), 32'h33);
    // Surviving pair disagrees: target held, no majority.
    drv(1, 1, 0, 8'h11, 8'h22, 8'h11);
    step();
    chk("r28_nomaj", 32'(no_maj), 32'h1);
    chk("r28_fault", 32'(fault), 32'h0);
    in_valid = 0;
    repeat (3) step();
    chk("r28_hold", 32'(cmd_o), 32'h33);
    drv(1, 1, 1, 8'h33, 8'h33, 8'h33);
    step();
    chk("r28_clr_failed", 32'(failed), 32'h0);
    chk("r28_clr_nomaj", 32'(no_maj), 32'h0);
    // Pass-through of copy A.
    drv(0, 1, 0, 8'h44, 8'h99, 8'h99);
    step();
    chk("r29_fault", 32'(fault), 32'h0);
    chk("r29_failed", 32'(failed), 32'h0);
    in_valid = 0;
    repeat (8) step();
    chk("r29_cmd", 32'(cmd_o), 32'h44);
    // Reset mid-ramp, then a fresh target.
    drv(1, 1, 0, 8'h0F, 8'h0F, 8'h0F);
    step();
    in_valid = 0;
    repeat (3) step();
    pulse_rst();
    drv(1, 1, 0, 8'hF0, 8'hF0, 8'hF0);
    step();
    in_valid = 0;
    repeat (16) step();
    chk("r30_cmd", 32'(cmd_o), 32'hF0);
    // Randomized traffic: mostly agreeing copies with occasional corrupted bits.
    for (int i = 0; i < 600; i++) begin
      base = N'($urandom);
      fb = ($urandom_range(0, 3) == 0) ? N'(1 << $urandom_range(0, N - 1)) : '0;
      fc = ($urandom_range(0, 2) == 0) ? N'(1 << $urandom_range(0, N - 1)) : '0;
      drv($urandom_range(0, 7) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0,
          ($urandom_range(0, 9) == 0) ? N'($urandom) : base, base ^ fb, base ^ fc);
      step();
      if ($urandom_range(0, 99) == 0) pulse_rst();
    end
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
